// File: rtl/pocket_video_pkg.sv
// -----------------------------------------------------------------------------
// pocket_video_pkg
// Shared types for the Pocket video preset sequencer and its helpers.
//   PRESET_W : width of a scaler preset code
//   preset_t : scaler preset code
//   state_e  : preset-change sequencer states
// -----------------------------------------------------------------------------
package pocket_video_pkg;

  localparam int unsigned PRESET_W = 3;

  typedef logic [PRESET_W-1:0] preset_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VS = 2'd1,
    MUTE    = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pocket_vs_edge.sv
// -----------------------------------------------------------------------------
// pocket_vs_edge
// Vsync rising-edge detector with a wrapping frame counter. Usable by any
// video block that needs frame-boundary timing.
//   clk_i       : pixel clock
//   rst_ni      : asynchronous active-low reset
//   vs_i        : Vsync level, active high, synchronous to clk_i
//   vs_rise_o   : high in the cycle where vs_i rises (combinational)
//   frame_cnt_o : count of Vsync rising edges, registered, wraps to 0
// -----------------------------------------------------------------------------
module pocket_vs_edge #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             vs_i,
  output logic             vs_rise_o,
  output logic [CNT_W-1:0] frame_cnt_o
);

  logic             vs_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign vs_rise_o   = vs_i & ~vs_q;
  assign frame_cnt_o = cnt_q;

  // Next frame count: advance on every Vsync rising edge, natural wrap.
  always_comb begin
    cnt_d = cnt_q;
    if (vs_rise_o) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Vsync history and frame counter registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vs_q  <= 1'b0;
      cnt_q <= {CNT_W{1'b0}};
    end else begin
      vs_q  <= vs_i;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pocket_video_mode_ctrl.sv
// -----------------------------------------------------------------------------
// pocket_video_mode_ctrl
// Sequences scaler preset changes for the Pocket display path. A request is
// taken over a req/ack handshake, the new preset is applied only on a Vsync
// rising edge (or forced after a timeout when Vsync is absent), and RGB is
// muted for MUTE_FRAMES whole frames after the switch so the scaler never
// sees a torn frame.
//   iPCLK       : pixel clock, sole clock
//   iRST_N      : asynchronous active-low reset
//   iREQ        : preset change request (level), sampled only in IDLE
//   iPRESET_REQ : requested preset, sampled with iREQ
//   iVS         : core Vsync level, active high
//   oPRESET     : active preset to the video output stage
//   oMUTE       : force RGB to 0 while high
//   oBUSY       : request accepted, not yet acknowledged
//   oACK        : one-cycle pulse, request complete
//   oTIMEOUT    : one-cycle pulse, switch forced without a Vsync edge
//   oFRAME_CNT  : count of Vsync rising edges, wraps
// -----------------------------------------------------------------------------
module pocket_video_mode_ctrl
  import pocket_video_pkg::*;
#(
  parameter int unsigned MUTE_FRAMES  = 2,
  parameter preset_t     RESET_PRESET = 3'd0,
  parameter int unsigned TIMEOUT_CLKS = 1048576
) (
  input  logic                iPCLK,
  input  logic                iRST_N,
  input  logic                iREQ,
  input  logic [PRESET_W-1:0] iPRESET_REQ,
  input  logic                iVS,
  output logic [PRESET_W-1:0] oPRESET,
  output logic                oMUTE,
  output logic                oBUSY,
  output logic                oACK,
  output logic                oTIMEOUT,
  output logic [15:0]         oFRAME_CNT
);

  localparam int unsigned MC_W = (MUTE_FRAMES == 0) ? 1 : $clog2(MUTE_FRAMES + 1);
  localparam int unsigned TO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [MC_W-1:0] MUTE_LOAD = MC_W'(MUTE_FRAMES);
  localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic            MUTE_ON   = (MUTE_FRAMES != 0);

  state_e          state_q,    state_d;
  preset_t         pending_q,  pending_d;
  preset_t         preset_q,   preset_d;
  logic            mute_q,     mute_d;
  logic            busy_q,     busy_d;
  logic            ack_q,      ack_d;
  logic            tout_q,     tout_d;
  logic [MC_W-1:0] mute_cnt_q, mute_cnt_d;
  logic [TO_W-1:0] to_cnt_q,   to_cnt_d;
  logic            vs_rise_s;
  logic            switch_s;

  pocket_vs_edge #(
    .CNT_W (16)
  ) u_vs_edge (
    .clk_i       (iPCLK),
    .rst_ni      (iRST_N),
    .vs_i        (iVS),
    .vs_rise_o   (vs_rise_s),
    .frame_cnt_o (oFRAME_CNT)
  );

  assign oPRESET  = preset_q;
  assign oMUTE    = mute_q;
  assign oBUSY    = busy_q;
  assign oACK     = ack_q;
  assign oTIMEOUT = tout_q;

  // Next-state and output logic of the preset-change sequencer.
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    preset_d   = preset_q;
    mute_d     = mute_q;
    busy_d     = busy_q;
    ack_d      = 1'b0;
    tout_d     = 1'b0;
    mute_cnt_d = mute_cnt_q;
    to_cnt_d   = to_cnt_q;
    switch_s   = 1'b0;

    case (state_q)
      IDLE: begin
        // A Vsync edge coinciding with acceptance is deliberately not used:
        // the switch waits for the next full frame boundary.
        if (iREQ) begin
          pending_d = iPRESET_REQ;
          busy_d    = 1'b1;
          if (iPRESET_REQ == preset_q) begin
            state_d = DONE;
          end else begin
            state_d  = WAIT_VS;
            to_cnt_d = {TO_W{1'b0}};
          end
        end else begin
          state_d = IDLE;
        end
      end

      WAIT_VS: begin
        if (vs_rise_s) begin
          switch_s = 1'b1;
        end else if (to_cnt_q == TO_LAST) begin
          switch_s = 1'b1;
          tout_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + {{(TO_W-1){1'b0}}, 1'b1};
        end

        if (switch_s) begin
          preset_d   = pending_q;
          mute_d     = MUTE_ON;
          mute_cnt_d = MUTE_LOAD;
          state_d    = MUTE_ON ? MUTE : DONE;
        end else begin
          state_d = WAIT_VS;
        end
      end

      MUTE: begin
        // mute_cnt counts the frames still to be blanked; the edge that
        // sees it at 1 ends the last muted frame.
        if (vs_rise_s) begin
          mute_cnt_d = mute_cnt_q - {{(MC_W-1){1'b0}}, 1'b1};
          if (mute_cnt_q == {{(MC_W-1){1'b0}}, 1'b1}) begin
            mute_d  = 1'b0;
            state_d = DONE;
          end else begin
            state_d = MUTE;
          end
        end else begin
          state_d = MUTE;
        end
      end

      DONE: begin
        ack_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        mute_d   = 1'b0;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge iPCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q    <= IDLE;
      pending_q  <= RESET_PRESET;
      preset_q   <= RESET_PRESET;
      mute_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      tout_q     <= 1'b0;
      mute_cnt_q <= {MC_W{1'b0}};
      to_cnt_q   <= {TO_W{1'b0}};
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      preset_q   <= preset_d;
      mute_q     <= mute_d;
      busy_q     <= busy_d;
      ack_q      <= ack_d;
      tout_q     <= tout_d;
      mute_cnt_q <= mute_cnt_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

endmodule

// File: tb/tb_pocket_video_mode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pocket_video_mode_ctrl
// Self-checking bench: a table of hand-derived vectors for the basic switch
// and same-preset handshakes, hand-written sequences for timeout, contention
// and mid-operation reset, and a randomized run against a behavioural model.
// A 4-bit pocket_vs_edge instance exposes the frame counter wrap cheaply.
// -----------------------------------------------------------------------------
module tb_pocket_video_mode_ctrl;

  localparam int         MF = 2;
  localparam int         TO = 16;
  localparam logic [2:0] RP = 3'd0;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_r;
  logic [2:0]  preq_r;
  logic        vs_r;
  logic [2:0]  preset_w;
  logic        mute_w, busy_w, ack_w, tout_w;
  logic [15:0] frames_w;
  logic        rise4_w;
  logic [3:0]  frames4_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pocket_video_mode_ctrl #(
    .MUTE_FRAMES  (MF),
    .RESET_PRESET (RP),
    .TIMEOUT_CLKS (TO)
  ) dut (
    .iPCLK       (clk),
    .iRST_N      (rst_n),
    .iREQ        (req_r),
    .iPRESET_REQ (preq_r),
    .iVS         (vs_r),
    .oPRESET     (preset_w),
    .oMUTE       (mute_w),
    .oBUSY       (busy_w),
    .oACK        (ack_w),
    .oTIMEOUT    (tout_w),
    .oFRAME_CNT  (frames_w)
  );

  pocket_vs_edge #(.CNT_W(4)) u_edge4 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .vs_i        (vs_r),
    .vs_rise_o   (rise4_w),
    .frame_cnt_o (frames4_w)
  );

  // ---------------- behavioural reference model ----------------
  // phase: 0 idle, 1 waiting for a frame boundary, 2 muting, 3 acknowledging
  logic [2:0]  m_preset, m_pending;
  logic        m_mute, m_busy, m_ack, m_tout, m_vs_prev;
  logic [15:0] m_frames;
  int          m_phase, m_wait, m_left;

  function automatic void model_reset();
    m_preset = RP; m_pending = RP; m_mute = 1'b0; m_busy = 1'b0;
    m_ack = 1'b0; m_tout = 1'b0; m_vs_prev = 1'b0; m_frames = 16'd0;
    m_phase = 0; m_wait = 0; m_left = 0;
  endfunction

  function automatic void model_clock(input logic r, input logic [2:0] p, input logic v);
    logic rise;
    rise      = v && !m_vs_prev;
    m_vs_prev = v;
    m_ack     = 1'b0;
    m_tout    = 1'b0;
    if (rise) m_frames = m_frames + 16'd1;
    case (m_phase)
      0: if (r) begin
           m_pending = p;
           m_busy    = 1'b1;
           if (p == m_preset) m_phase = 3;
           else begin m_phase = 1; m_wait = 0; end
         end
      1: if (rise || m_wait == TO - 1) begin
           m_tout   = !rise;
           m_preset = m_pending;
           m_mute   = (MF != 0);
           m_left   = MF;
           m_phase  = (MF != 0) ? 2 : 3;
         end else m_wait = m_wait + 1;
      2: if (rise) begin
           m_left = m_left - 1;
           if (m_left == 0) begin m_mute = 1'b0; m_phase = 3; end
         end
      default: begin m_ack = 1'b1; m_busy = 1'b0; m_phase = 0; end
    endcase
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_model(input string name);
    logic [27:0] act, exp;
    act = {preset_w, mute_w, busy_w, ack_w, tout_w, frames_w, frames4_w, rise4_w};
    exp = {m_preset, m_mute, m_busy, m_ack, m_tout, m_frames, m_frames[3:0],
           vs_r & ~m_vs_prev};
    total++;
    if (act !== exp) begin
      bad++;
      if (bad < 40) $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic [2:0] p, input logic v);
    req_r = r; preq_r = p; vs_r = v;
    @(posedge clk);
    model_clock(r, p, v);
    #1;
  endtask

  typedef struct {
    logic        req;
    logic [2:0]  p;
    logic        vs;
    logic [2:0]  e_preset;
    logic        e_mute;
    logic        e_busy;
    logic        e_ack;
    logic [15:0] e_frames;
  } vec_t;

  vec_t tbl [12];

  initial begin
    bit seen;
    logic [15:0] f0;

    // basic switch to preset 3 with two muted frames, then same-preset request
    tbl[0]  = '{1'b1, 3'd3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[1]  = '{1'b0, 3'd3, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 16'd0};
    tbl[2]  = '{1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[3]  = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 16'd1};
    tbl[4]  = '{1'b0, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[5]  = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b1, 1'b1, 1'b0, 16'd2};
    tbl[6]  = '{1'b0, 3'd3, 1'b1, 3'd3, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[7]  = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[8]  = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 16'd3};
    tbl[9]  = '{1'b1, 3'd3, 1'b0, 3'd3, 1'b0, 1'b1, 1'b0, 16'd3};
    tbl[10] = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b1, 16'd3};
    tbl[11] = '{1'b0, 3'd3, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 16'd3};

    // ---- 1. reset ----
    rst_n = 1'b0; req_r = 1'b0; preq_r = 3'd0; vs_r = 1'b0;
    model_reset();
    #12;
    check("reset_outputs", 32'({preset_w, mute_w, busy_w, ack_w, tout_w, frames_w, frames4_w}),
          32'({RP, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0}));
    #10 rst_n = 1'b1;

    // ---- 2/3. table vectors ----
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].req, tbl[i].p, tbl[i].vs);
      check($sformatf("vec%0d", i),
            32'({preset_w, mute_w, busy_w, ack_w, tout_w, frames_w}),
            32'({tbl[i].e_preset, tbl[i].e_mute, tbl[i].e_busy, tbl[i].e_ack, 1'b0, tbl[i].e_frames}));
      check_model($sformatf("vec%0d_model", i));
    end

    // ---- 4. timeout with Vsync held low ----
    step(1'b1, 3'd5, 1'b0);
    check("to_accept_busy", 32'(busy_w), 32'd1);
    for (int k = 1; k <= 16; k++) begin
      step(1'b0, 3'd5, 1'b0);
      check_model($sformatf("to_wait%0d", k));
      if (k < 16) check($sformatf("to_pre%0d", k), 32'({preset_w, tout_w}), 32'({3'd3, 1'b0}));
      else        check("to_fire", 32'({preset_w, tout_w, mute_w}), 32'({3'd5, 1'b1, 1'b1}));
    end
    step(1'b0, 3'd0, 1'b0);
    check("to_pulse_end", 32'({tout_w, mute_w}), 32'({1'b0, 1'b1}));
    step(1'b0, 3'd0, 1'b1);
    check("to_mute_rise1", 32'(mute_w), 32'd1);
    step(1'b0, 3'd0, 1'b0);
    step(1'b0, 3'd0, 1'b1);
    check("to_mute_rise2", 32'(mute_w), 32'd0);
    step(1'b0, 3'd0, 1'b0);
    check("to_ack", 32'({ack_w, busy_w}), 32'({1'b1, 1'b0}));
    check_model("to_ack_model");

    // ---- 5. contention: coincident edge at acceptance, request while busy ----
    f0 = m_frames;
    step(1'b1, 3'd2, 1'b1);
    check("ct_accept", 32'({busy_w, preset_w, frames_w}), 32'({1'b1, 3'd5, f0 + 16'd1}));
    step(1'b1, 3'd7, 1'b0);
    step(1'b1, 3'd7, 1'b0);
    check("ct_no_switch", 32'({preset_w, mute_w}), 32'({3'd5, 1'b0}));
    step(1'b1, 3'd7, 1'b1);
    check("ct_switch", 32'({preset_w, mute_w}), 32'({3'd2, 1'b1}));
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(mute_w, 3'd7, ~vs_r);
      check_model($sformatf("ct_run%0d", i));
      seen = ack_w;
    end
    check("ct_ack_seen", 32'(seen), 32'd1);
    check("ct_final_preset", 32'(preset_w), 32'd2);
    step(1'b0, 3'd0, vs_r);
    check("ct_idle", 32'(busy_w), 32'd0);

    // ---- 6. reset in the middle of MUTE ----
    step(1'b1, 3'd6, 1'b0);
    step(1'b0, 3'd6, 1'b1);
    check("rs_in_mute", 32'({preset_w, mute_w}), 32'({3'd6, 1'b1}));
    step(1'b0, 3'd6, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rs_async", 32'({preset_w, mute_w, busy_w, ack_w, frames_w, frames4_w}),
          32'({RP, 1'b0, 1'b0, 1'b0, 16'd0, 4'd0}));
    model_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("rs_no_ack%0d", i), 32'({ack_w, busy_w}), 32'd0);
    end
    #3 rst_n = 1'b1;
    step(1'b1, 3'd4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step(1'b0, 3'd4, ~vs_r);
      check_model($sformatf("rs_run%0d", i));
      seen = ack_w;
    end
    check("rs_ack_seen", 32'(seen), 32'd1);
    check("rs_final_preset", 32'(preset_w), 32'd4);

    // ---- randomized run: frequent Vsync, then sparse Vsync to hit timeouts ----
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic [2:0] p;
      logic       v;
      r = ($urandom_range(0, 5) == 0);
      p = 3'($urandom_range(0, 7));
      v = vs_r;
      if ($urandom_range(0, (i < 1500) ? 3 : 40) == 0) v = ~vs_r;
      step(r, p, v);
      check_model("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pocket_video_mode_ctrl.md
Name: pocket_video_mode_ctrl

Overview:
Sequences video-preset (scaler mode) changes for the Pocket display path. It accepts preset-change requests from the bridge/command side over a req/ack handshake and applies the new preset only on a frame boundary (Vsync rising edge). It mutes video for a configurable number of whole frames around the switch, so the APF scaler never sees a torn frame. It sits between the command/bridge logic and the generic Pocket video output stage, driving that stage's preset input and an RGB mute.

Parameters:
- MUTE_FRAMES, 2, number of full frames oMUTE stays high after a switch; 0 means no mute.
- RESET_PRESET, 3'd0, value of oPRESET after reset.
- TIMEOUT_CLKS, 1048576, clocks to wait in WAIT_VS before forcing the switch without a Vsync edge; must be ≥ 2.

Ports:
- iPCLK  in  1  display pixel clock; sole clock.
- iRST_N  in  1  asynchronous active-low reset.
- iREQ  in  1  preset change request, level; sampled only in IDLE.
- iPRESET_REQ  in  3  requested preset; sampled with iREQ.
- iVS  in  1  core Vsync, level, active high, synchronous to iPCLK.
- oPRESET  out  3  active preset, to video output stage.
- oMUTE  out  1  force RGB to 0 when high.
- oBUSY  out  1  request accepted and not yet acknowledged.
- oACK  out  1  single-cycle pulse: request complete.
- oTIMEOUT  out  1  single-cycle pulse: switch forced by timeout.
- oFRAME_CNT  out  16  count of Vsync rising edges; wraps.

Behaviour:
- Reset (async assert, sync release):
  - oPRESET=RESET_PRESET.
  - oMUTE, oBUSY, oACK and oTIMEOUT are 0.
  - oFRAME_CNT=0; vs_q=0; state=IDLE; counters are 0.
- Edge detect: vs_rise = iVS & ~vs_q; vs_q <= iVS every cycle. All outputs are registered, so a response appears 1 clock after the cycle in which vs_rise=1.
- oFRAME_CNT increments on every vs_rise, in every state; 16'hFFFF -> 0.
- States: IDLE, WAIT_VS, MUTE, DONE.
- IDLE (oBUSY=0):
  - If iREQ=1: latch pending=iPRESET_REQ and set oBUSY=1.
    - If pending==oPRESET -> DONE. No mute, no preset write.
    - Else -> WAIT_VS and clear the timeout counter.
  - A vs_rise in the same cycle as acceptance is ignored for switching.
- WAIT_VS:
  - On vs_rise: oPRESET<=pending; oMUTE<=(MUTE_FRAMES!=0); mute_cnt<=MUTE_FRAMES.
    - Next state MUTE if MUTE_FRAMES!=0, else DONE.
  - Else, if the timeout counter reaches TIMEOUT_CLKS-1: perform the same actions as on vs_rise, and pulse oTIMEOUT for 1 cycle.
  - Otherwise the timeout counter increments.
- MUTE: on each vs_rise, mute_cnt decrements. When mute_cnt==1 at a vs_rise: oMUTE<=0 and go to DONE. The timeout does not apply here.
- DONE: oACK=1 for exactly 1 cycle, oBUSY<=0, -> IDLE. iREQ is not sampled in DONE; a held iREQ is re-accepted in IDLE on the next cycle.
- iREQ while BUSY is ignored. The requester deasserts iREQ after oACK.
- oPRESET changes only in WAIT_VS, on vs_rise or timeout; it never changes mid-frame otherwise.
- Reset asserted mid-operation aborts the operation: no oACK is produced, and all state returns to reset values.
- Widths:
  - mute_cnt is $clog2(MUTE_FRAMES+1) bits, minimum 1.
  - The timeout counter is $clog2(TIMEOUT_CLKS) bits.

Decomposition:
- Shared package pocket_video_pkg:
  - state enum (IDLE, WAIT_VS, MUTE, DONE);
  - preset_t (logic [2:0]);
  - PRESET_W=3.
- One natural sub-module: pocket_vs_edge. It registers iVS and outputs vs_rise plus the wrapping 16-bit frame counter. It is reusable by other video blocks.
- The FSM, mute counter and timeout counter stay in the top.

Test Plan:
1. Reset with MUTE_FRAMES=2, RESET_PRESET=0 -> oPRESET=0, oMUTE=0, oBUSY=0, oFRAME_CNT=0.
2. Basic switch: iREQ=1 with preset=3 in IDLE, then Vsync pulses -> preset and mute follow the frame boundaries.
   - oBUSY rises the next cycle.
   - oPRESET=3 and oMUTE=1 one clock after the first vs_rise.
   - oMUTE=0 one clock after the 3rd vs_rise.
   - oACK pulses once, the following cycle.
3. Same preset: iREQ with preset equal to oPRESET -> no preset write, no mute, and oACK 2 cycles after iREQ is sampled.
4. No Vsync, TIMEOUT_CLKS=16: iREQ with preset=5 and iVS held 0 -> the switch is forced by the timeout.
   - oPRESET=5 and oTIMEOUT=1 for one cycle, 16 clocks after entry to WAIT_VS.
   - oMUTE=1 until 2 later vs_rise.
5. Contention: a second iREQ (preset=7) while BUSY, and a vs_rise coincident with acceptance.
   - The second request is ignored; oPRESET ends at the first request's value.
   - The coincident vs_rise does not switch; the switch occurs at the next edge.
   - oFRAME_CNT counts every edge, including 16'hFFFF -> 0 wrap after 65536 frames.
6. Reset mid-MUTE: assert iRST_N=0 asynchronously between edges -> immediate return to reset values, no oACK; a new request afterward completes normally.
